// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx
// -------------
// Serialises a two-character ASCII pair (high character first) as 8N1 UART
// frames, optionally followed by CR LF, so that the countdown value shows up
// on a host terminal.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2 or more)
//   SEND_CRLF     1: message is hi, lo, 0x0D, 0x0A; 0: message is hi, lo
//
// Ports:
//   clock_i     system clock, all state changes on posedge
//   reset_i     asynchronous active-high reset
//   ascii_in_i  character pair, [15:8] sent first; sampled only on accept
//   send_i      request strobe, accepted only while idle
//   busy_o      high from the accepting edge until the message completes
//   tx_o        registered serial line, idle high
//   sent_o      one-cycle pulse on the edge where the message completes
module ascii_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          SEND_CRLF    = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] ascii_in_i,
  input  logic        send_i,
  output logic        busy_o,
  output logic        tx_o,
  output logic        sent_o
);

  localparam int unsigned NBYTES = SEND_CRLF ? 4 : 2;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [15:0]         buf_q, buf_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                sent_q, sent_d;

  logic [7:0]          cur_byte;
  logic [2:0]          next_bit;
  logic                baud_last;

  // Byte currently on the wire; CR LF are constants, not part of the buffer.
  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = buf_q[15:8];
      2'd1:    cur_byte = buf_q[7:0];
      2'd2:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign next_bit  = bit_idx_q + 3'd1;
  assign baud_last = (baud_cnt_q == BAUD_LAST);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  // tx is registered, so every branch loads the level of the bit that will
  // be on the line during the following cycle.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    sent_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send_i) begin
          buf_d      = ascii_in_i;
          byte_idx_d = 2'd0;
          baud_cnt_d = '0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          tx_d       = cur_byte[0];
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (byte_idx_q < LAST_BYTE) begin
            // Next start bit follows the stop bit directly, no idle gap.
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            busy_d  = 1'b0;
            sent_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign sent_o = sent_q;

endmodule

// File: doc/ascii_uart_tx.md
Name: ascii_uart_tx

Overview:
- Downstream consumer of the two-digit ASCII countdown counter.
- On a `send` strobe, latches the 16-bit ASCII pair (high char first) and serializes it as 8N1 UART frames on `tx`.
- Optionally appends CR LF after the pair.
- Drives the board serial line so the countdown value is visible on a host terminal.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit. Legal range is 2 or more; the bench uses 4 and silicon uses clk/baud.
- SEND_CRLF, 1, when 1 each message is 4 bytes (hi, lo, 0x0D, 0x0A); when 0 each message is 2 bytes (hi, lo).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- ascii_in  input  16  character pair; [15:8] is sent first, [7:0] second. Sampled only on an accepted send.
- send  input  1  request strobe; accepted only when idle.
- busy  output  1  high from the accepting edge until the message completes.
- tx  output  1  serial line, idle high; registered.
- sent  output  1  one-cycle pulse at message completion.

Behaviour:
- Reset (async, immediate, also mid-message): tx=1, busy=0, sent=0, state=IDLE. Bit, byte and baud counters clear to 0. The latched buffer value is don't-care.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If send=1 at a posedge: latch ascii_in, byte_idx=0, busy<=1, tx<=0, baud_cnt<=0, go to START.
  - The start bit is therefore visible the cycle after the accepting edge (1-cycle latency).
- Bit timing: each bit holds tx for exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1, and the bit advances on the edge where baud_cnt==CLKS_PER_BIT-1.
- START: tx=0 for one bit time, then go to DATA with bit_idx=0.
- DATA:
  - tx = current byte[bit_idx], LSB first, 8 bits.
  - After bit 7, go to STOP.
- STOP: tx=1 for one bit time, then:
  - If byte_idx < NBYTES-1: byte_idx+1, go to START with no extra idle bit.
  - Else: go to IDLE, busy<=0 and sent<=1 on the same edge.
- Message duration: NBYTES*10*CLKS_PER_BIT cycles from the accepting edge to the edge where busy falls.
  - NBYTES = 4 if SEND_CRLF else 2.
- Byte selection:
  - idx0 = buffer[15:8]
  - idx1 = buffer[7:0]
  - idx2 = 8'h0D
  - idx3 = 8'h0A
- Bytes are sent verbatim with no validation; "UN" and non-digits are sent as-is.
- send while busy=1 is ignored, not queued. This includes the completion edge itself, where busy was still 1 before the edge.
- ascii_in changes while busy have no effect on the message in flight.
- sent is high for exactly one cycle and 0 otherwise.
- A new send may be accepted on the first edge after busy falls; sent and the new start bit may then be adjacent.
- send held high continuously yields back-to-back messages, each separated by one idle-high cycle.

Test Plan:
- Reset behaviour: assert reset mid-cycle with no clock edge -> tx=1, busy=0, sent=0 immediately; after release, tx stays 1 with send=0.
- Single message ("42"), CLKS_PER_BIT=4, SEND_CRLF=1: ascii_in="42", send pulse at edge k ->
  - tx low from k+1 for 4 cycles.
  - Data bits 0,0,1,0,1,1,0,0 (0x34), then stop bit.
  - Then bytes 0x32, 0x0D, 0x0A.
  - busy falls and sent=1 exactly at edge k+160, for one cycle.
  - Decoded bytes = 34 32 0D 0A.
- SEND_CRLF=0 with ascii_in="UN" -> bytes 0x55, 0x4E only; sent at edge k+80.
- Busy protection: send pulses at k+10 and k+159, with ascii_in changed to "07" at k+5 -> both pulses ignored; transmitted bytes still match the pair latched at k.
- Back-to-back: send held high for 2 messages ("09" then "08", changing ascii_in after the first accept) -> second message starts at k+161; exactly one idle-high cycle between messages; sent pulses twice.
- Mid-message reset: reset during the DATA of byte 1 -> tx returns to 1 asynchronously; a subsequent send restarts cleanly from byte 0 with correct framing.
